id_ex_stage: RTL and testbench

//  ID/EX pipeline register plus EX-side operand select for the RV64I core. Captures decoded

---
 rtl/rv_pkg.sv | 45 ++++
 rtl/fwd_unit.sv | 32 +++
 rtl/id_ex_stage.sv | 111 +++++++++++
 tb/tb_id_ex_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV64I pipeline definitions: datapath widths, ALU operation codes
// and the ID/EX pipeline register layout.
package rv_pkg;

    localparam int XLEN = 64;
    localparam int RA_W = 5;
    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [OP_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [OP_W-1:0] ALU_NOR = 4'b1100;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic            alu_src;
        logic [OP_W-1:0] alu_op;
        logic            reg_write;
        logic            mem_read;
    } id_ex_t;

    // A bubble never writes back or loads; ALUop parks at ADD so the ALU output stays benign.
    localparam id_ex_t BUBBLE = '{
        valid:     1'b0,
        rs1:       '0,
        rs2:       '0,
        rd:        '0,
        rs1_data:  '0,
        rs2_data:  '0,
        imm:       '0,
        alu_src:   1'b0,
        alu_op:    ALU_ADD,
        reg_write: 1'b0,
        mem_read:  1'b0
    };

endpackage

// File: rtl/fwd_unit.sv
// Per-operand bypass mux: picks the youngest in-flight producer of rs
// (EX/MEM before MEM/WB), otherwise the value read from the regfile.
module fwd_unit
    import rv_pkg::*;
(
    input  logic [RA_W-1:0] rs,
    input  logic [XLEN-1:0] reg_data,
    input  logic [RA_W-1:0] exm_rd,
    input  logic            exm_reg_write,
    input  logic [XLEN-1:0] exm_result,
    input  logic [RA_W-1:0] mwb_rd,
    input  logic            mwb_reg_write,
    input  logic [XLEN-1:0] mwb_result,
    output logic [XLEN-1:0] fwd
);

    logic exm_hit;
    logic mwb_hit;

    // x0 is hardwired, so a producer naming x0 must never override the captured zero.
    assign exm_hit = exm_reg_write && (exm_rd != '0) && (exm_rd == rs);
    assign mwb_hit = mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs);

    always_comb begin
        fwd = reg_data;
        if (exm_hit)
            fwd = exm_result;
        else if (mwb_hit)
            fwd = mwb_result;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding, immediate select
// and single-bubble load-use hazard detection.
module id_ex_stage
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_alu_src,
    input  logic [OP_W-1:0] id_alu_op,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            stall,
    input  logic            flush,
    input  logic [RA_W-1:0] exm_rd,
    input  logic            exm_reg_write,
    input  logic [XLEN-1:0] exm_result,
    input  logic [RA_W-1:0] mwb_rd,
    input  logic            mwb_reg_write,
    input  logic [XLEN-1:0] mwb_result,
    output logic            hazard_stall,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [OP_W-1:0] alu_op,
    output logic            ex_valid,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic [XLEN-1:0] ex_rs2_fwd
);

    id_ex_t ex_q;
    id_ex_t id_entry;
    logic   load_use;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    always_comb begin
        id_entry = '{
            valid:     id_valid,
            rs1:       id_rs1,
            rs2:       id_rs2,
            rd:        id_rd,
            rs1_data:  id_rs1_data,
            rs2_data:  id_rs2_data,
            imm:       id_imm,
            alu_src:   id_alu_src,
            alu_op:    id_alu_op,
            reg_write: id_reg_write,
            mem_read:  id_mem_read
        };
    end

    // rs2 only matters for the hazard when the consumer actually reads it (not an imm form).
    assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                      ((ex_q.rd == id_rs1) || ((ex_q.rd == id_rs2) && !id_alu_src));
    assign hazard_stall = load_use && !flush && !reset;

    always_ff @(posedge clk) begin
        if (reset)
            ex_q <= BUBBLE;
        else if (flush)
            ex_q <= BUBBLE;
        else if (stall)
            ex_q <= ex_q;
        else if (hazard_stall)
            ex_q <= BUBBLE;
        else
            ex_q <= id_entry;
    end

    fwd_unit u_fwd_rs1 (
        .rs            (ex_q.rs1),
        .reg_data      (ex_q.rs1_data),
        .exm_rd        (exm_rd),
        .exm_reg_write (exm_reg_write),
        .exm_result    (exm_result),
        .mwb_rd        (mwb_rd),
        .mwb_reg_write (mwb_reg_write),
        .mwb_result    (mwb_result),
        .fwd           (fwd_rs1)
    );

    fwd_unit u_fwd_rs2 (
        .rs            (ex_q.rs2),
        .reg_data      (ex_q.rs2_data),
        .exm_rd        (exm_rd),
        .exm_reg_write (exm_reg_write),
        .exm_result    (exm_result),
        .mwb_rd        (mwb_rd),
        .mwb_reg_write (mwb_reg_write),
        .mwb_result    (mwb_result),
        .fwd           (fwd_rs2)
    );

    assign alu_in1      = fwd_rs1;
    assign alu_in2      = ex_q.alu_src ? ex_q.imm : fwd_rs2;
    assign alu_op       = ex_q.alu_op;
    assign ex_valid     = ex_q.valid;
    assign ex_rd        = ex_q.rd;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_rs2_fwd   = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by a
// randomized instruction stream checked against a behavioural model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [63:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_alu_src;
    logic [3:0]  id_alu_op;
    logic        id_reg_write, id_mem_read;
    logic        stall, flush;
    logic [4:0]  exm_rd, mwb_rd;
    logic        exm_reg_write, mwb_reg_write;
    logic [63:0] exm_result, mwb_result;
    logic        hazard_stall;
    logic [63:0] alu_in1, alu_in2, ex_rs2_fwd;
    logic [3:0]  alu_op;
    logic        ex_valid, ex_reg_write, ex_mem_read;
    logic [4:0]  ex_rd;

    int assertCount = 0;
    int failCount   = 0;

    // Behavioural picture of the instruction sitting in EX
    logic        mValid, mSrc, mRw, mMr;
    logic [4:0]  mRs1, mRs2, mRd;
    logic [63:0] mD1, mD2, mImm;
    logic [3:0]  mOp;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .stall(stall), .flush(flush),
        .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result),
        .hazard_stall(hazard_stall), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_op(alu_op), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rs2_fwd(ex_rs2_fwd)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                                 input logic [4:0] rd, input logic [63:0] d1, input logic [63:0] d2,
                                 input logic [63:0] imm, input logic src, input logic [3:0] op,
                                 input logic rw, input logic mr);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_alu_src = src; id_alu_op = op; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] modelFwd(input logic [4:0] rs, input logic [63:0] regVal);
        if (rs == 0) return regVal;
        if (exm_reg_write && exm_rd == rs) return exm_result;
        if (mwb_reg_write && mwb_rd == rs) return mwb_result;
        return regVal;
    endfunction

    function automatic logic modelHazard();
        logic usesRd;
        if (reset || flush || !mValid || !mMr || mRd == 0 || !id_valid) return 1'b0;
        usesRd = (id_rs1 == mRd) || (!id_alu_src && id_rs2 == mRd);
        return usesRd;
    endfunction

    task automatic modelBubble();
        mValid = 0; mRw = 0; mMr = 0; mOp = 4'b0010; mSrc = 0;
        mRs1 = 0; mRs2 = 0; mRd = 0; mD1 = 0; mD2 = 0; mImm = 0;
    endtask

    task automatic modelCheck(input int cyc);
        logic [63:0] e2;
        e2 = modelFwd(mRs2, mD2);
        checkOutput($sformatf("rnd%0d hazard", cyc), {63'd0, hazard_stall}, {63'd0, modelHazard()});
        checkOutput($sformatf("rnd%0d alu_in1", cyc), alu_in1, modelFwd(mRs1, mD1));
        checkOutput($sformatf("rnd%0d alu_in2", cyc), alu_in2, mSrc ? mImm : e2);
        checkOutput($sformatf("rnd%0d rs2_fwd", cyc), ex_rs2_fwd, e2);
        checkOutput($sformatf("rnd%0d alu_op", cyc), {60'd0, alu_op}, {60'd0, mOp});
        checkOutput($sformatf("rnd%0d ctrl", cyc), {ex_valid, ex_rd, ex_reg_write, ex_mem_read},
                    {mValid, mRd, mRw, mMr});
    endtask

    initial begin
        reset = 1; stall = 0; flush = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 0);
        exm_rd = 0; exm_reg_write = 0; exm_result = 0;
        mwb_rd = 0; mwb_reg_write = 0; mwb_result = 0;

        tick(); tick();
        checkOutput("reset ex_valid", {63'd0, ex_valid}, 64'd0);
        checkOutput("reset alu_op", {60'd0, alu_op}, 64'h2);
        checkOutput("reset alu_in1", alu_in1, 64'd0);
        checkOutput("reset alu_in2", alu_in2, 64'd0);

        // ADD x3,x1,x2
        reset = 0;
        applyStimulus(1, 1, 2, 3, 64'd5, 64'd7, 64'd0, 0, 4'b0010, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 0);
        #2;
        checkOutput("add alu_in1", alu_in1, 64'd5);
        checkOutput("add alu_in2", alu_in2, 64'd7);
        checkOutput("add alu_op", {60'd0, alu_op}, 64'h2);
        checkOutput("add ex_rd", {59'd0, ex_rd}, 64'd3);

        // Forwarding priority on rs1=x4
        applyStimulus(1, 4, 0, 8, 64'h11, 64'd0, 64'd0, 0, 4'b0001, 1, 0);
        tick();
        exm_rd = 4; exm_reg_write = 1; exm_result = 64'hAA;
        mwb_rd = 4; mwb_reg_write = 1; mwb_result = 64'hBB;
        #2;
        checkOutput("fwd exm wins", alu_in1, 64'hAA);
        exm_reg_write = 0;
        #2;
        checkOutput("fwd mwb", alu_in1, 64'hBB);
        applyStimulus(1, 0, 0, 8, 64'd0, 64'd0, 64'd0, 0, 4'b0001, 1, 0);
        tick();
        exm_rd = 0; exm_reg_write = 1; exm_result = 64'hCC;
        mwb_rd = 0; mwb_reg_write = 1; mwb_result = 64'hDD;
        #2;
        checkOutput("fwd x0", alu_in1, 64'd0);
        exm_reg_write = 0; mwb_reg_write = 0;

        // Load-use: LD x5 then ADD x6,x5,x1
        applyStimulus(1, 2, 0, 5, 64'd0, 64'd0, 64'd8, 1, 4'b0010, 1, 1);
        tick();
        applyStimulus(1, 5, 1, 6, 64'd1, 64'd2, 64'd0, 0, 4'b0010, 1, 0);
        #2;
        checkOutput("lu hazard", {63'd0, hazard_stall}, 64'd1);
        tick();
        checkOutput("lu bubble valid", {63'd0, ex_valid}, 64'd0);
        checkOutput("lu bubble rw", {63'd0, ex_reg_write}, 64'd0);
        checkOutput("lu hazard clear", {63'd0, hazard_stall}, 64'd0);
        tick();
        checkOutput("lu consumer", {ex_valid, ex_rd}, {1'b1, 5'd6});

        // ADDI rs2 field matches the load but is unused
        applyStimulus(1, 2, 0, 5, 64'd0, 64'd0, 64'd8, 1, 4'b0010, 1, 1);
        tick();
        applyStimulus(1, 1, 5, 7, 64'd3, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1, 4'b0010, 1, 0);
        #2;
        checkOutput("addi no hazard", {63'd0, hazard_stall}, 64'd0);
        tick();
        checkOutput("addi imm", alu_in2, 64'hFFFF_FFFF_FFFF_FFFF);

        // Stall holds, then flush beats stall
        applyStimulus(1, 1, 2, 9, 64'd3, 64'd4, 64'd0, 0, 4'b0110, 1, 0);
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
                          5'($urandom_range(10, 31)), {$urandom, $urandom}, {$urandom, $urandom},
                          {$urandom, $urandom}, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            tick();
            checkOutput($sformatf("stall%0d ctrl", i), {ex_valid, ex_rd, ex_reg_write, ex_mem_read},
                        {1'b1, 5'd9, 1'b1, 1'b0});
            checkOutput($sformatf("stall%0d op", i), {60'd0, alu_op}, 64'h6);
            checkOutput($sformatf("stall%0d in1", i), alu_in1, 64'd3);
        end
        flush = 1;
        tick();
        flush = 0; stall = 0;
        checkOutput("flush bubble", {ex_valid, ex_reg_write, ex_mem_read, alu_op}, {3'b000, 4'b0010});

        // Reset mid-instruction masks hazard and discards EX
        applyStimulus(1, 2, 0, 5, 64'd0, 64'd0, 64'd8, 1, 4'b0010, 1, 1);
        tick();
        applyStimulus(1, 5, 0, 6, 64'd0, 64'd0, 64'd0, 0, 4'b0010, 1, 0);
        reset = 1;
        #2;
        checkOutput("reset masks hazard", {63'd0, hazard_stall}, 64'd0);
        tick();
        checkOutput("reset discards", {ex_valid, ex_reg_write, ex_mem_read}, 3'b000);

        // Randomized stream against the behavioural model
        tick();
        reset = 0;
        modelBubble();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic isLoad;
            logic nV, nS, nRw, nMr;
            logic [4:0] n1, n2, nd;
            logic [63:0] nD1, nD2, nI;
            logic [3:0] nOp;
            isLoad = ($urandom_range(0, 3) == 0);
            reset  = ($urandom_range(0, 49) == 0);
            flush  = ($urandom_range(0, 19) == 0);
            stall  = ($urandom_range(0, 9) == 0);
            applyStimulus(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                          isLoad | 1'($urandom), 4'($urandom), isLoad | 1'($urandom), isLoad);
            exm_rd = 5'($urandom_range(0, 7)); exm_reg_write = 1'($urandom);
            exm_result = {$urandom, $urandom};
            mwb_rd = 5'($urandom_range(0, 7)); mwb_reg_write = 1'($urandom);
            mwb_result = {$urandom, $urandom};
            @(negedge clk);
            modelCheck(cyc);
            nV = id_valid; n1 = id_rs1; n2 = id_rs2; nd = id_rd; nD1 = id_rs1_data;
            nD2 = id_rs2_data; nI = id_imm; nS = id_alu_src; nOp = id_alu_op;
            nRw = id_reg_write; nMr = id_mem_read;
            if (reset || flush) begin
                tick();
                modelBubble();
            end else if (stall) begin
                tick();
            end else if (modelHazard()) begin
                tick();
                modelBubble();
            end else begin
                tick();
                mValid = nV; mRs1 = n1; mRs2 = n2; mRd = nd; mD1 = nD1; mD2 = nD2;
                mImm = nI; mSrc = nS; mOp = nOp; mRw = nRw; mMr = nMr;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
